// File: rtl/bellek_hakem_pkg.sv
// Shared state/owner encodings and grant-vector layout for the memory-port arbiter.
package bellek_hakem_pkg;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        ISTEK = 2'd1,
        YANIT = 2'd2
    } durum_t;

    typedef enum logic {
        SAHIP_L1B = 1'b0,
        SAHIP_L1V = 1'b1
    } sahip_t;

    localparam int unsigned IZIN_BIT = 2;
    localparam int unsigned IZIN_L1B = 0;
    localparam int unsigned IZIN_L1V = 1;

endpackage

// File: rtl/iki_yollu_hakem.sv
// Two-input round-robin grant: on a tie the requester that did not win last time is granted.
module iki_yollu_hakem
    import bellek_hakem_pkg::*;
(
    input  logic                istek_b,
    input  logic                istek_v,
    input  sahip_t              son_sahip,
    input  logic                etkin,
    output logic [IZIN_BIT-1:0] izin
);

    always_comb begin
        izin = '0;
        if (etkin) begin
            if (istek_b && istek_v) begin
                if (son_sahip == SAHIP_L1B) begin
                    izin[IZIN_L1V] = 1'b1;
                end else begin
                    izin[IZIN_L1B] = 1'b1;
                end
            end else begin
                izin[IZIN_L1B] = istek_b;
                izin[IZIN_L1V] = istek_v;
            end
        end
    end

endmodule

// File: rtl/bellek_hakem.sv
// Arbitrates the shared memory port between the I-cache (l1b) and D-cache (l1v) miss paths,
// one transaction in flight, with fetch-flush cancellation of instruction responses.
module bellek_hakem
    import bellek_hakem_pkg::*;
#(
    parameter int unsigned ADRES_BIT = 32,
    parameter int unsigned VERI_BIT  = 32,
    parameter int unsigned MASKE_BIT = VERI_BIT / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADRES_BIT-1:0] l1b_istek_adres_i,
    input  logic                 l1b_istek_gecerli_i,
    output logic                 l1b_istek_hazir_o,
    input  logic                 l1b_iptal_i,
    output logic [VERI_BIT-1:0]  l1b_yanit_veri_o,
    output logic                 l1b_yanit_gecerli_o,
    input  logic [ADRES_BIT-1:0] l1v_istek_adres_i,
    input  logic                 l1v_istek_yaz_i,
    input  logic [VERI_BIT-1:0]  l1v_istek_veri_i,
    input  logic [MASKE_BIT-1:0] l1v_istek_maske_i,
    input  logic                 l1v_istek_gecerli_i,
    output logic                 l1v_istek_hazir_o,
    output logic [VERI_BIT-1:0]  l1v_yanit_veri_o,
    output logic                 l1v_yanit_gecerli_o,
    output logic [ADRES_BIT-1:0] bellek_istek_adres_o,
    output logic                 bellek_istek_yaz_o,
    output logic [VERI_BIT-1:0]  bellek_istek_veri_o,
    output logic [MASKE_BIT-1:0] bellek_istek_maske_o,
    output logic                 bellek_istek_gecerli_o,
    input  logic                 bellek_istek_hazir_i,
    input  logic [VERI_BIT-1:0]  bellek_yanit_veri_i,
    input  logic                 bellek_yanit_gecerli_i,
    output logic                 bellek_yanit_hazir_o
);

    durum_t              durum;
    sahip_t              sahip;
    sahip_t              son_sahip;
    logic                iptal;
    logic [IZIN_BIT-1:0] izin;

    // A flushed fetch is not a candidate; grants only in BOSTA and never during reset.
    iki_yollu_hakem u_hakem (
        .istek_b   (l1b_istek_gecerli_i && !l1b_iptal_i),
        .istek_v   (l1v_istek_gecerli_i),
        .son_sahip (son_sahip),
        .etkin     ((durum == BOSTA) && !rst_i),
        .izin      (izin)
    );

    assign l1b_istek_hazir_o      = izin[IZIN_L1B];
    assign l1v_istek_hazir_o      = izin[IZIN_L1V];
    assign bellek_istek_gecerli_o = (durum == ISTEK);
    assign bellek_yanit_hazir_o   = (durum == YANIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum                <= BOSTA;
            sahip                <= SAHIP_L1V;
            son_sahip            <= SAHIP_L1V;
            iptal                <= 1'b0;
            bellek_istek_adres_o <= '0;
            bellek_istek_yaz_o   <= 1'b0;
            bellek_istek_veri_o  <= '0;
            bellek_istek_maske_o <= '0;
            l1b_yanit_veri_o     <= '0;
            l1b_yanit_gecerli_o  <= 1'b0;
            l1v_yanit_veri_o     <= '0;
            l1v_yanit_gecerli_o  <= 1'b0;
        end else begin
            l1b_yanit_gecerli_o <= 1'b0;
            l1v_yanit_gecerli_o <= 1'b0;
            case (durum)
                BOSTA: begin
                    if (izin[IZIN_L1B]) begin
                        bellek_istek_adres_o <= l1b_istek_adres_i;
                        bellek_istek_yaz_o   <= 1'b0;
                        bellek_istek_veri_o  <= '0;
                        bellek_istek_maske_o <= '1;
                        sahip                <= SAHIP_L1B;
                        son_sahip            <= SAHIP_L1B;
                        durum                <= ISTEK;
                    end else if (izin[IZIN_L1V]) begin
                        bellek_istek_adres_o <= l1v_istek_adres_i;
                        bellek_istek_yaz_o   <= l1v_istek_yaz_i;
                        bellek_istek_veri_o  <= l1v_istek_veri_i;
                        bellek_istek_maske_o <= l1v_istek_maske_i;
                        sahip                <= SAHIP_L1V;
                        son_sahip            <= SAHIP_L1V;
                        durum                <= ISTEK;
                    end
                end
                ISTEK: begin
                    if ((sahip == SAHIP_L1B) && l1b_iptal_i) begin
                        iptal <= 1'b1;
                    end
                    if (bellek_istek_hazir_i) begin
                        durum <= YANIT;
                    end
                end
                YANIT: begin
                    if ((sahip == SAHIP_L1B) && l1b_iptal_i) begin
                        iptal <= 1'b1;
                    end
                    // A flush arriving with the response still discards it.
                    if (bellek_yanit_gecerli_i) begin
                        durum <= BOSTA;
                        iptal <= 1'b0;
                        if (sahip == SAHIP_L1V) begin
                            l1v_yanit_veri_o    <= bellek_yanit_veri_i;
                            l1v_yanit_gecerli_o <= 1'b1;
                        end else if (!(iptal || l1b_iptal_i)) begin
                            l1b_yanit_veri_o    <= bellek_yanit_veri_i;
                            l1b_yanit_gecerli_o <= 1'b1;
                        end
                    end
                end
                default: durum <= BOSTA;
            endcase
        end
    end

    yanit_protokol: assert property (@(posedge clk_i) disable iff (rst_i)
        bellek_yanit_gecerli_i |-> bellek_yanit_hazir_o);

endmodule

// File: tb/tb_bellek_hakem.sv
// Transaction-level bench for bellek_hakem: directed test-plan rounds then random rounds,
// checked against a round-robin/ownership model kept here.
module tb_bellek_hakem;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] l1b_istek_adres_i;
    logic        l1b_istek_gecerli_i;
    logic        l1b_istek_hazir_o;
    logic        l1b_iptal_i;
    logic [31:0] l1b_yanit_veri_o;
    logic        l1b_yanit_gecerli_o;
    logic [31:0] l1v_istek_adres_i;
    logic        l1v_istek_yaz_i;
    logic [31:0] l1v_istek_veri_i;
    logic [3:0]  l1v_istek_maske_i;
    logic        l1v_istek_gecerli_i;
    logic        l1v_istek_hazir_o;
    logic [31:0] l1v_yanit_veri_o;
    logic        l1v_yanit_gecerli_o;
    logic [31:0] bellek_istek_adres_o;
    logic        bellek_istek_yaz_o;
    logic [31:0] bellek_istek_veri_o;
    logic [3:0]  bellek_istek_maske_o;
    logic        bellek_istek_gecerli_o;
    logic        bellek_istek_hazir_i;
    logic [31:0] bellek_yanit_veri_i;
    logic        bellek_yanit_gecerli_i;
    logic        bellek_yanit_hazir_o;

    bellek_hakem dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .l1b_istek_adres_i      (l1b_istek_adres_i),
        .l1b_istek_gecerli_i    (l1b_istek_gecerli_i),
        .l1b_istek_hazir_o      (l1b_istek_hazir_o),
        .l1b_iptal_i            (l1b_iptal_i),
        .l1b_yanit_veri_o       (l1b_yanit_veri_o),
        .l1b_yanit_gecerli_o    (l1b_yanit_gecerli_o),
        .l1v_istek_adres_i      (l1v_istek_adres_i),
        .l1v_istek_yaz_i        (l1v_istek_yaz_i),
        .l1v_istek_veri_i       (l1v_istek_veri_i),
        .l1v_istek_maske_i      (l1v_istek_maske_i),
        .l1v_istek_gecerli_i    (l1v_istek_gecerli_i),
        .l1v_istek_hazir_o      (l1v_istek_hazir_o),
        .l1v_yanit_veri_o       (l1v_yanit_veri_o),
        .l1v_yanit_gecerli_o    (l1v_yanit_gecerli_o),
        .bellek_istek_adres_o   (bellek_istek_adres_o),
        .bellek_istek_yaz_o     (bellek_istek_yaz_o),
        .bellek_istek_veri_o    (bellek_istek_veri_o),
        .bellek_istek_maske_o   (bellek_istek_maske_o),
        .bellek_istek_gecerli_o (bellek_istek_gecerli_o),
        .bellek_istek_hazir_i   (bellek_istek_hazir_i),
        .bellek_yanit_veri_i    (bellek_yanit_veri_i),
        .bellek_yanit_gecerli_i (bellek_yanit_gecerli_i),
        .bellek_yanit_hazir_o   (bellek_yanit_hazir_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who won the last grant, last delivered data per cache, pending pulses.
    logic        m_son_b;
    logic [31:0] m_b_veri;
    logic [31:0] m_v_veri;
    logic        m_pb;
    logic        m_pv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_son_b  = 1'b0;
        m_b_veri = '0;
        m_v_veri = '0;
        m_pb     = 1'b0;
        m_pv     = 1'b0;
    endtask

    task automatic chk_yanitlar(input string tag);
        chk({tag, "_b_puls"}, 32'(l1b_yanit_gecerli_o), 32'(m_pb));
        chk({tag, "_v_puls"}, 32'(l1v_yanit_gecerli_o), 32'(m_pv));
        chk({tag, "_b_veri"}, l1b_yanit_veri_o, m_b_veri);
        chk({tag, "_v_veri"}, l1v_yanit_veri_o, m_v_veri);
    endtask

    // One arbitration round starting in BOSTA. iptal_an indexes cycles after the grant
    // (ISTEK cycles first, then YANIT cycles including the response cycle); -1 means none.
    task automatic tur(input logic bv, input logic vv, input logic ip,
                       input logic [31:0] ba, input logic [31:0] va, input logic [31:0] vd,
                       input logic vy, input logic [3:0] vm,
                       input int bekle, input int gecik, input int iptal_an,
                       input logic [31:0] yd, input logic sifirla);
        logic gb, gv, iptal_edildi;
        logic [31:0] ea;
        int k;
        @(negedge clk_i);
        l1b_istek_gecerli_i    = bv;
        l1b_istek_adres_i      = ba;
        l1b_iptal_i            = ip;
        l1v_istek_gecerli_i    = vv;
        l1v_istek_adres_i      = va;
        l1v_istek_veri_i       = vd;
        l1v_istek_yaz_i        = vy;
        l1v_istek_maske_i      = vm;
        bellek_istek_hazir_i   = 1'b0;
        bellek_yanit_gecerli_i = 1'b0;
        #1;
        chk_yanitlar("bosta");
        chk("bosta_mem_gecerli", 32'(bellek_istek_gecerli_o), 32'd0);
        chk("bosta_yanit_hazir", 32'(bellek_yanit_hazir_o), 32'd0);
        m_pb = 1'b0;
        m_pv = 1'b0;
        gb = bv && !ip;
        gv = vv;
        if (gb && gv) begin
            if (m_son_b) gb = 1'b0;
            else         gv = 1'b0;
        end
        chk("hazir_b", 32'(l1b_istek_hazir_o), 32'(gb));
        chk("hazir_v", 32'(l1v_istek_hazir_o), 32'(gv));
        if (!gb && !gv) return;
        m_son_b      = gb;
        ea           = gb ? ba : va;
        iptal_edildi = 1'b0;
        k            = 0;
        for (int i = 0; i <= bekle; i++) begin
            @(negedge clk_i);
            l1b_istek_gecerli_i  = 1'b0;
            l1v_istek_gecerli_i  = 1'b0;
            l1b_iptal_i          = (k == iptal_an);
            bellek_istek_hazir_i = (i == bekle) && !sifirla;
            rst_i                = sifirla;
            if (l1b_iptal_i && gb) iptal_edildi = 1'b1;
            #1;
            chk("istek_gecerli", 32'(bellek_istek_gecerli_o), 32'd1);
            chk("istek_adres", bellek_istek_adres_o, ea);
            chk("istek_yaz", 32'(bellek_istek_yaz_o), gb ? 32'd0 : 32'(vy));
            chk("istek_maske", 32'(bellek_istek_maske_o), gb ? 32'hF : 32'(vm));
            if (!gb) chk("istek_veri", bellek_istek_veri_o, vd);
            chk("istek_hazirlar", 32'({l1b_istek_hazir_o, l1v_istek_hazir_o}), 32'd0);
            chk("istek_yanit_hazir", 32'(bellek_yanit_hazir_o), 32'd0);
            chk("istek_puls", 32'({l1b_yanit_gecerli_o, l1v_yanit_gecerli_o}), 32'd0);
            k++;
            if (sifirla) begin
                @(negedge clk_i);
                rst_i       = 1'b0;
                l1b_iptal_i = 1'b0;
                #1;
                model_reset();
                chk("rst_mem_gecerli", 32'(bellek_istek_gecerli_o), 32'd0);
                chk("rst_yanit_hazir", 32'(bellek_yanit_hazir_o), 32'd0);
                chk_yanitlar("rst");
                return;
            end
        end
        for (int j = 0; j <= gecik; j++) begin
            @(negedge clk_i);
            bellek_istek_hazir_i   = 1'b0;
            l1b_iptal_i            = (k == iptal_an);
            bellek_yanit_gecerli_i = (j == gecik);
            bellek_yanit_veri_i    = yd;
            if (l1b_iptal_i && gb) iptal_edildi = 1'b1;
            #1;
            chk("yanit_hazir", 32'(bellek_yanit_hazir_o), 32'd1);
            chk("yanit_mem_gecerli", 32'(bellek_istek_gecerli_o), 32'd0);
            chk("yanit_puls", 32'({l1b_yanit_gecerli_o, l1v_yanit_gecerli_o}), 32'd0);
            k++;
        end
        if (gb) begin
            if (!iptal_edildi) begin
                m_pb     = 1'b1;
                m_b_veri = yd;
            end
        end else begin
            m_pv     = 1'b1;
            m_v_veri = yd;
        end
    endtask

    initial begin
        rst_i                  = 1'b1;
        l1b_istek_adres_i      = '0;
        l1b_istek_gecerli_i    = 1'b0;
        l1b_iptal_i            = 1'b0;
        l1v_istek_adres_i      = '0;
        l1v_istek_yaz_i        = 1'b0;
        l1v_istek_veri_i       = '0;
        l1v_istek_maske_i      = '0;
        l1v_istek_gecerli_i    = 1'b0;
        bellek_istek_hazir_i   = 1'b0;
        bellek_yanit_veri_i    = '0;
        bellek_yanit_gecerli_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        chk("reset_mem_gecerli", 32'(bellek_istek_gecerli_o), 32'd0);
        chk("reset_yanit_hazir", 32'(bellek_yanit_hazir_o), 32'd0);
        chk("reset_hazirlar", 32'({l1b_istek_hazir_o, l1v_istek_hazir_o}), 32'd0);
        chk_yanitlar("reset");
        rst_i = 1'b0;

        // Single instruction read.
        tur(1, 0, 0, 32'h1000, 0, 0, 0, 0, 0, 2, -1, 32'hDEADBEEF, 0);
        // Both requesting continuously: grants alternate.
        for (int i = 0; i < 4; i++)
            tur(1, 1, 0, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'hA0 + 32'(i), 0, 4'hF,
                0, 1, -1, 32'hC000 + 32'(i), 0);
        // Data write with the memory stalling four cycles.
        tur(0, 1, 0, 0, 32'h2000, 32'h12345678, 1, 4'b0011, 4, 1, -1, 32'h0, 0);
        // Instruction read flushed while waiting for the response.
        tur(1, 0, 0, 32'h3000, 0, 0, 0, 0, 0, 2, 2, 32'hBAD0BAD0, 0);
        // Flushed in the very cycle the response arrives.
        tur(1, 0, 0, 32'h3004, 0, 0, 0, 0, 1, 1, 3, 32'hBAD1BAD1, 0);
        tur(1, 0, 0, 32'h3008, 0, 0, 0, 0, 0, 0, -1, 32'h600DF00D, 0);
        // Flush in BOSTA suppresses l1b; l1v wins.
        tur(1, 1, 1, 32'h4000, 32'h5000, 32'h55, 0, 4'hF, 0, 0, -1, 32'h77, 0);
        // Flush while l1v owns the port has no effect.
        tur(0, 1, 0, 0, 32'h5004, 32'h66, 0, 4'hF, 0, 1, 1, 32'h88, 0);
        // Reset during ISTEK, then a tie must go to l1b.
        tur(0, 1, 0, 0, 32'h6000, 32'h99, 1, 4'h3, 2, 0, -1, 0, 1);
        tur(1, 1, 0, 32'h7000, 32'h7100, 32'h1, 0, 4'hF, 0, 0, -1, 32'hAB, 0);

        for (int r = 0; r < 150; r++) begin
            int bk, gk, ia;
            bk = int'($urandom_range(0, 3));
            gk = int'($urandom_range(0, 3));
            ia = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, bk + 1 + gk)) : -1;
            tur(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                $urandom, $urandom, $urandom, 1'($urandom), 4'($urandom),
                bk, gk, ia, $urandom, 0);
        end
        tur(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bellek_hakem.md
Name: bellek_hakem

Overview:
- Arbitrates the shared lower-level memory port between the instruction cache miss path (l1b) and the data cache miss path (l1v).
- One transaction is in flight at a time. Requesters are granted round-robin.
- Instruction-side requests can be cancelled on a fetch flush; a cancelled request's response is absorbed and never forwarded.
- Sits between the L1 caches and the memory interface / bus bridge.

Parameters:
ADRES_BIT, 32, address width of all request ports
VERI_BIT, 32, data width of request/response payloads
MASKE_BIT, 4, byte-enable width (VERI_BIT/8)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
l1b_istek_adres_i  input  ADRES_BIT  instruction read address
l1b_istek_gecerli_i  input  1  instruction request valid
l1b_istek_hazir_o  output  1  instruction request accepted this cycle
l1b_iptal_i  input  1  fetch flush: cancel pending/in-flight instruction request
l1b_yanit_veri_o  output  VERI_BIT  instruction response data
l1b_yanit_gecerli_o  output  1  instruction response valid (1-cycle pulse)
l1v_istek_adres_i  input  ADRES_BIT  data address
l1v_istek_yaz_i  input  1  1=write, 0=read
l1v_istek_veri_i  input  VERI_BIT  write data
l1v_istek_maske_i  input  MASKE_BIT  write byte enables
l1v_istek_gecerli_i  input  1  data request valid
l1v_istek_hazir_o  output  1  data request accepted this cycle
l1v_yanit_veri_o  output  VERI_BIT  read data (don't-care for write ack)
l1v_yanit_gecerli_o  output  1  data response / write ack valid (1-cycle pulse)
bellek_istek_adres_o  output  ADRES_BIT  memory address
bellek_istek_yaz_o  output  1  memory write
bellek_istek_veri_o  output  VERI_BIT  memory write data
bellek_istek_maske_o  output  MASKE_BIT  memory byte enables (all ones for l1b reads)
bellek_istek_gecerli_o  output  1  memory request valid
bellek_istek_hazir_i  input  1  memory accepts request
bellek_yanit_veri_i  input  VERI_BIT  memory response data
bellek_yanit_gecerli_i  input  1  memory response valid (reads and write acks)
bellek_yanit_hazir_o  output  1  arbiter accepts response

Behaviour:
- Reset (rst_i=1 at clock edge), regardless of state:
  - state=BOSTA, all valid/hazir outputs 0, response data registers 0, son_sahip=L1V, iptal flag=0.
  - Any in-flight memory transaction is abandoned; the memory side is reset together with this block.
- States: BOSTA, ISTEK, YANIT.
- BOSTA:
  - Grant candidates: l1b if l1b_istek_gecerli_i && !l1b_iptal_i; l1v if l1v_istek_gecerli_i.
  - Both candidates: grant the one != son_sahip. One candidate: grant it.
  - Grant drives that requester's istek_hazir_o=1 combinationally in the same cycle.
  - On grant, register adres/yaz/veri/maske (l1b: yaz=0, maske=all ones), set sahip and son_sahip, go to ISTEK.
  - istek_hazir_o is 0 in every state other than BOSTA.
- ISTEK:
  - bellek_istek_gecerli_o=1 with the registered payload, held stable until bellek_istek_hazir_i.
  - On the handshake, go to YANIT.
  - Latency: bellek_istek_gecerli_o rises the cycle after grant.
- YANIT:
  - bellek_yanit_hazir_o=1 (0 in all other states).
  - On bellek_yanit_gecerli_i: register bellek_yanit_veri_i into the owner's yanit_veri_o, pulse the owner's yanit_gecerli_o for exactly one cycle on the next cycle, go to BOSTA.
- Responses have no backpressure; the caches must accept a response the cycle it is presented.
- yanit_veri_o holds its last value until the next response to that owner.
- Throughput: the next grant can occur in the cycle the previous response pulse is visible (2-cycle turnaround minimum).
- Cancellation:
  - l1b_iptal_i while sahip=l1b in ISTEK or YANIT, including the cycle the response arrives: set the iptal flag.
  - The memory transaction still completes; no request retraction after gecerli is raised.
  - The response is accepted and discarded: l1b_yanit_gecerli_o stays 0. The flag clears on return to BOSTA.
- l1b_iptal_i in BOSTA: suppresses l1b candidacy that cycle only; l1v may be granted.
- l1b_iptal_i while sahip=l1v: no effect.
- bellek_yanit_gecerli_i in BOSTA or ISTEK is ignored (hazir 0). This is a protocol error and is flagged by assertion in simulation.

Decomposition:
- In sabitler.vh: state encodings (BOSTA=2'd0, ISTEK=2'd1, YANIT=2'd2) and owner encodings (SAHIP_L1B=1'b0, SAHIP_L1V=1'b1).
- Sub-module iki_yollu_hakem: 2-input round-robin grant logic.
  - Inputs: two requests, son_sahip, enable.
  - Output: one-hot grant.
  - Reusable for future multi-master memory ports.

Test Plan:
- Single l1b read, adres=0x1000, memory hazir immediately, response 0xDEADBEEF 3 cycles later -> l1b_istek_hazir_o high 1 cycle; bellek_istek_gecerli_o the next cycle with maske=4'hF, yaz=0; l1b_yanit_gecerli_o one pulse with 0xDEADBEEF; l1v outputs stay 0.
- l1b and l1v valid continuously from reset, each response 2 cycles after accept -> grants alternate l1b, l1v, l1b, l1v; each yanit pulse goes only to the matching owner.
- l1v write, adres=0x2000, veri=0x12345678, maske=4'b0011, bellek_istek_hazir_i held low 4 cycles -> payload stable all 4 cycles; write ack gives a l1v_yanit_gecerli_o pulse.
- l1b read in flight, l1b_iptal_i pulsed in YANIT before the response -> response accepted (bellek_yanit_hazir_o=1), l1b_yanit_gecerli_o stays 0, next grant proceeds normally.
- l1b_iptal_i and l1b_istek_gecerli_i high in BOSTA with l1v also valid -> l1v granted, l1b_istek_hazir_o=0.
- rst_i asserted while in ISTEK -> next cycle all gecerli/hazir outputs 0, state BOSTA; first tie after reset grants l1b.
